// File: rtl/val2_iter_shifter_pkg.sv
// -----------------------------------------------------------------------------
// val2_iter_shifter_pkg
// Shared encodings for the iterative ARM operand2 shifter:
//   shift_t  - barrel-shift type codes as they appear in operand[6:5]
//   state_t  - control FSM state encoding
//   rrx_t    - flag marking a single-step rotate-right-extended operation
//   decode_shift() - maps the raw 2-bit operand field onto shift_t
// -----------------------------------------------------------------------------
package val2_iter_shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    typedef enum logic {
        RRX_OFF = 1'b0,
        RRX_ON  = 1'b1
    } rrx_t;

    // Translate the operand[6:5] field into a shift type.
    function automatic shift_t decode_shift(input logic [1:0] code);
        shift_t res;
        case (code)
            2'b00:   res = SH_LSL;
            2'b01:   res = SH_LSR;
            2'b10:   res = SH_ASR;
            2'b11:   res = SH_ROR;
            default: res = SH_LSL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/val2_step_shifter.sv
// -----------------------------------------------------------------------------
// val2_step_shifter
// Combinational single-step shifter: moves data by k (0..STEP) positions in the
// selected direction and reports the last bit shifted out. k == 0 passes data
// and carry through untouched. When rrx is set the step is a one-bit rotate
// through carry regardless of k.
// Ports:
//   data      in  DATA_W  value to shift
//   k         in  KW      shift distance for this step, 0..STEP
//   mode      in  shift_t LSL / LSR / ASR / ROR
//   rrx       in  rrx_t   rotate-right-extended request
//   carry_in  in  1       carry before this step
//   result    out DATA_W  shifted value
//   carry_out out 1       last bit shifted out (carry_in when k == 0)
// -----------------------------------------------------------------------------
module val2_step_shifter
    import val2_iter_shifter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 8,
    parameter int KW     = $clog2(STEP + 1)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [KW-1:0]     k,
    input  shift_t            mode,
    input  rrx_t              rrx,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    // One extra bit on the shifted-out side captures the carry directly.
    logic [DATA_W:0]   lsl_s;
    logic [DATA_W:0]   lsr_s;
    logic [DATA_W:0]   asr_s;
    logic [DATA_W-1:0] ror_s;

    // Candidate results for every shift type.
    always_comb begin
        lsl_s = {1'b0, data} << k;
        lsr_s = {data, 1'b0} >> k;
        asr_s = $signed({data, 1'b0}) >>> k;
        ror_s = (data >> k) | (data << (DATA_W - 32'(k)));
    end

    // Select the result and carry for the requested shift type.
    always_comb begin
        result    = data;
        carry_out = carry_in;
        if (rrx == RRX_ON) begin
            result    = {carry_in, data[DATA_W-1:1]};
            carry_out = data[0];
        end else if (k != KW'(0)) begin
            case (mode)
                SH_LSL: begin
                    result    = lsl_s[DATA_W-1:0];
                    carry_out = lsl_s[DATA_W];
                end
                SH_LSR: begin
                    result    = lsr_s[DATA_W:1];
                    carry_out = lsr_s[0];
                end
                SH_ASR: begin
                    result    = asr_s[DATA_W:1];
                    carry_out = asr_s[0];
                end
                SH_ROR: begin
                    result    = ror_s;
                    carry_out = ror_s[DATA_W-1];
                end
                default: begin
                    result    = data;
                    carry_out = carry_in;
                end
            endcase
        end else begin
            result    = data;
            carry_out = carry_in;
        end
    end

endmodule

// File: rtl/val2_iter_shifter.sv
// -----------------------------------------------------------------------------
// val2_iter_shifter
// Iterative ARM operand2 shifter. A request is decoded on acceptance into a
// working value, a shift type and a remaining distance; the distance is then
// consumed at most STEP bits per cycle. The result is published only on
// entry to DONE and held until the consumer takes it.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   in_valid/in_ready request handshake (ready only in IDLE)
//   shifter_operand   12-bit operand2 field
//   I, mem_en         immediate form / memory-offset form (mem_en wins)
//   reg_shift         amount from val_Rs[7:0] instead of operand[11:7]
//   val_Rm, val_Rs    register operand and shift-amount register
//   carry_in          current C flag
//   out_valid/out_ready result handshake (valid only in DONE)
//   val2, carry_out   shifter result and carry
// -----------------------------------------------------------------------------
module val2_iter_shifter
    import val2_iter_shifter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       shifter_operand,
    input  logic              I,
    input  logic              mem_en,
    input  logic              reg_shift,
    input  logic [DATA_W-1:0] val_Rm,
    input  logic [DATA_W-1:0] val_Rs,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val2,
    output logic              carry_out
);

    // Distance counter must hold DATA_W+1 (over-long LSL/LSR).
    localparam int AMT_W = $clog2(DATA_W + 2);
    localparam int KW    = $clog2(STEP + 1);

    localparam logic [31:0] LSL_MAX  = 32'(DATA_W + 1);
    localparam logic [31:0] ASR_MAX  = 32'(DATA_W);
    localparam logic [31:0] ROR_MASK = 32'(DATA_W - 1);
    localparam logic [31:0] STEP_32  = 32'(STEP);

    // Registered state
    state_t            state_r;
    logic [DATA_W-1:0] work_r;
    shift_t            mode_r;
    logic [AMT_W-1:0]  amt_r;
    logic              carry_r;
    rrx_t              rrx_r;
    logic [DATA_W-1:0] val2_r;
    logic              carry_out_r;
    logic              in_ready_r;
    logic              out_valid_r;

    // Next-state values
    state_t            state_nxt_s;
    logic [DATA_W-1:0] work_nxt_s;
    shift_t            mode_nxt_s;
    logic [AMT_W-1:0]  amt_nxt_s;
    logic              carry_nxt_s;
    rrx_t              rrx_nxt_s;
    logic [DATA_W-1:0] val2_nxt_s;
    logic              carry_out_nxt_s;

    // Request decode
    shift_t            op_mode_s;
    logic [7:0]        raw_s;
    logic [31:0]       raw32_s;
    logic [31:0]       ror_mod_s;
    logic [DATA_W-1:0] dec_work_s;
    shift_t            dec_mode_s;
    logic [31:0]       dec_amt32_s;
    logic [AMT_W-1:0]  dec_amt_s;
    logic              dec_carry_s;
    rrx_t              dec_rrx_s;

    // Step datapath
    logic [31:0]       amt32_s;
    logic [31:0]       k32_s;
    logic [KW-1:0]     step_k_s;
    logic [AMT_W-1:0]  amt_after_s;
    logic [DATA_W-1:0] step_result_s;
    logic              step_carry_s;

    // Only the low byte of Rs is a shift amount.
    logic              unused_rs_s;
    assign unused_rs_s = ^{val_Rs[DATA_W-1:8], 1'b0};

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign val2      = val2_r;
    assign carry_out = carry_out_r;

    // Decode an incoming request into working value, shift type and distance.
    always_comb begin
        op_mode_s   = decode_shift(shifter_operand[6:5]);
        raw_s       = reg_shift ? val_Rs[7:0] : {3'b000, shifter_operand[11:7]};
        raw32_s     = {24'd0, raw_s};
        ror_mod_s   = raw32_s & ROR_MASK;
        dec_work_s  = val_Rm;
        dec_mode_s  = op_mode_s;
        dec_amt32_s = 32'd0;
        dec_carry_s = carry_in;
        dec_rrx_s   = RRX_OFF;
        if (mem_en) begin
            dec_work_s = {{(DATA_W-12){shifter_operand[11]}}, shifter_operand};
            dec_mode_s = SH_LSL;
        end else if (I) begin
            // Rotating by zero leaves carry_in; otherwise the rotate itself
            // leaves result[MSB] as the last bit out.
            dec_work_s  = {{(DATA_W-8){1'b0}}, shifter_operand[7:0]};
            dec_mode_s  = SH_ROR;
            dec_amt32_s = {27'd0, shifter_operand[11:8], 1'b0};
        end else if (raw_s == 8'd0) begin
            if (reg_shift) begin
                dec_amt32_s = 32'd0;
            end else begin
                // Immediate #0 encodes LSR/ASR #DATA_W and RRX.
                case (op_mode_s)
                    SH_LSL: dec_amt32_s = 32'd0;
                    SH_LSR: dec_amt32_s = ASR_MAX;
                    SH_ASR: dec_amt32_s = ASR_MAX;
                    SH_ROR: begin
                        dec_amt32_s = 32'd1;
                        dec_rrx_s   = RRX_ON;
                    end
                    default: dec_amt32_s = 32'd0;
                endcase
            end
        end else begin
            case (op_mode_s)
                SH_LSL, SH_LSR: dec_amt32_s = (raw32_s > LSL_MAX) ? LSL_MAX : raw32_s;
                SH_ASR:         dec_amt32_s = (raw32_s > ASR_MAX) ? ASR_MAX : raw32_s;
                SH_ROR: begin
                    // A whole number of turns leaves the value intact but
                    // still reports the MSB as carry.
                    dec_amt32_s = ror_mod_s;
                    if (ror_mod_s == 32'd0) begin
                        dec_carry_s = val_Rm[DATA_W-1];
                    end else begin
                        dec_carry_s = carry_in;
                    end
                end
                default: dec_amt32_s = 32'd0;
            endcase
        end
        dec_amt_s = AMT_W'(dec_amt32_s);
    end

    // Size of this cycle's step and the distance left afterwards.
    always_comb begin
        amt32_s     = 32'(amt_r);
        k32_s       = (amt32_s < STEP_32) ? amt32_s : STEP_32;
        step_k_s    = KW'(k32_s);
        amt_after_s = amt_r - AMT_W'(k32_s);
    end

    val2_step_shifter #(
        .DATA_W (DATA_W),
        .STEP   (STEP),
        .KW     (KW)
    ) u_step (
        .data      (work_r),
        .k         (step_k_s),
        .mode      (mode_r),
        .rrx       (rrx_r),
        .carry_in  (carry_r),
        .result    (step_result_s),
        .carry_out (step_carry_s)
    );

    // Next-state and datapath update logic.
    always_comb begin
        state_nxt_s     = state_r;
        work_nxt_s      = work_r;
        mode_nxt_s      = mode_r;
        amt_nxt_s       = amt_r;
        carry_nxt_s     = carry_r;
        rrx_nxt_s       = rrx_r;
        val2_nxt_s      = val2_r;
        carry_out_nxt_s = carry_out_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    work_nxt_s  = dec_work_s;
                    mode_nxt_s  = dec_mode_s;
                    amt_nxt_s   = dec_amt_s;
                    carry_nxt_s = dec_carry_s;
                    rrx_nxt_s   = dec_rrx_s;
                    if (dec_amt_s != AMT_W'(0)) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s     = ST_DONE;
                        val2_nxt_s      = dec_work_s;
                        carry_out_nxt_s = dec_carry_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_nxt_s  = step_result_s;
                carry_nxt_s = step_carry_s;
                amt_nxt_s   = amt_after_s;
                rrx_nxt_s   = RRX_OFF;
                if (amt_after_s == AMT_W'(0)) begin
                    // Publish only the finished value.
                    state_nxt_s     = ST_DONE;
                    val2_nxt_s      = step_result_s;
                    carry_out_nxt_s = step_carry_s;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                amt_nxt_s   = AMT_W'(0);
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_r      <= {DATA_W{1'b0}};
            mode_r      <= SH_LSL;
            amt_r       <= AMT_W'(0);
            carry_r     <= 1'b0;
            rrx_r       <= RRX_OFF;
            val2_r      <= {DATA_W{1'b0}};
            carry_out_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            work_r      <= work_nxt_s;
            mode_r      <= mode_nxt_s;
            amt_r       <= amt_nxt_s;
            carry_r     <= carry_nxt_s;
            rrx_r       <= rrx_nxt_s;
            val2_r      <= val2_nxt_s;
            carry_out_r <= carry_out_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_val2_iter_shifter.sv
// -----------------------------------------------------------------------------
// tb_val2_iter_shifter
// Directed vectors with hand-computed results for the iterative operand2
// shifter (DATA_W=32, STEP=8): value, carry and acceptance-to-valid latency.
// -----------------------------------------------------------------------------
module tb_val2_iter_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] shifter_operand = 12'h000;
    logic        I = 1'b0;
    logic        mem_en = 1'b0;
    logic        reg_shift = 1'b0;
    logic [31:0] val_Rm = 32'h0;
    logic [31:0] val_Rs = 32'h0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] val2;
    logic        carry_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    val2_iter_shifter #(.DATA_W(32), .STEP(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .shifter_operand (shifter_operand),
        .I               (I),
        .mem_en          (mem_en),
        .reg_shift       (reg_shift),
        .val_Rm          (val_Rm),
        .val_Rs          (val_Rs),
        .carry_in        (carry_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .val2            (val2),
        .carry_out       (carry_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic i_f, input logic mem_f, input logic rs_f,
                             input logic [11:0] op, input logic [31:0] rm,
                             input logic [31:0] rs, input logic cin);
        I               = i_f;
        mem_en          = mem_f;
        reg_shift       = rs_f;
        shifter_operand = op;
        val_Rm          = rm;
        val_Rs          = rs;
        carry_in        = cin;
        in_valid        = 1'b1;
    endtask

    // Scramble inputs after acceptance so the DUT cannot depend on them.
    task automatic scramble();
        in_valid        = 1'b0;
        I               = 1'b0;
        mem_en          = 1'b0;
        reg_shift       = 1'b1;
        shifter_operand = ~shifter_operand;
        val_Rm          = ~val_Rm;
        val_Rs          = 32'h0000_0003;
        carry_in        = ~carry_in;
    endtask

    task automatic run_vec(input string tag, input logic i_f, input logic mem_f,
                           input logic rs_f, input logic [11:0] op,
                           input logic [31:0] rm, input logic [31:0] rs,
                           input logic cin, input logic [31:0] exp_v,
                           input logic exp_c, input int exp_lat, input int hold);
        int   lat;
        logic stable;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        drive_req(i_f, mem_f, rs_f, op, rm, rs, cin);
        @(posedge clk);
        #1;
        scramble();
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_val2"}, 64'(val2), 64'(exp_v));
        check({tag, "_carry"}, 64'(carry_out), 64'(exp_c));
        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                // A competing request while DONE must be ignored.
                drive_req(1'b1, 1'b0, 1'b0, 12'h0FF, 32'h0, 32'h0, 1'b1);
                if (val2 !== exp_v || carry_out !== exp_c || in_ready !== 1'b0 || out_valid !== 1'b1)
                    stable = 1'b0;
            end
            check({tag, "_hold"}, 64'(stable), 64'(1));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_release"}, {62'd0, out_valid, in_ready}, 64'h1);
    endtask

    initial begin
        int ov_seen;
        repeat (2) @(negedge clk);
        check("reset_state", {31'd0, in_ready, out_valid, carry_out, val2}, {31'd0, 1'b1, 1'b0, 1'b0, 32'h0});
        rst = 1'b1;

        //       tag          I     mem   reg   op       Rm            Rs           cin   exp_v         c     lat hold
        run_vec("imm_ror8",  1'b1, 1'b0, 1'b0, 12'h4FF, 32'h0,        32'h0,       1'b0, 32'hFF000000, 1'b1, 2, 0);
        run_vec("imm_rot0",  1'b1, 1'b0, 1'b0, 12'h0AB, 32'h0,        32'h0,       1'b1, 32'h000000AB, 1'b1, 1, 0);
        run_vec("lsl31",     1'b0, 1'b0, 1'b0, 12'hF80, 32'h1,        32'h0,       1'b1, 32'h80000000, 1'b0, 5, 0);
        run_vec("rrx",       1'b0, 1'b0, 1'b0, 12'h060, 32'h3,        32'h0,       1'b1, 32'h80000001, 1'b1, 2, 0);
        run_vec("reg_lsr40", 1'b0, 1'b0, 1'b1, 12'h020, 32'hFFFFFFFF, 32'd40,      1'b1, 32'h0,        1'b0, 6, 0);
        run_vec("reg_asr32", 1'b0, 1'b0, 1'b1, 12'h040, 32'h80000000, 32'd32,      1'b0, 32'hFFFFFFFF, 1'b1, 5, 0);
        run_vec("mem_neg",   1'b0, 1'b1, 1'b0, 12'h800, 32'h12345678, 32'h0,       1'b0, 32'hFFFFF800, 1'b0, 1, 3);
        run_vec("mem_over_i",1'b1, 1'b1, 1'b0, 12'h7FF, 32'h0,        32'h0,       1'b1, 32'h000007FF, 1'b1, 1, 0);
        run_vec("imm_lsr0",  1'b0, 1'b0, 1'b0, 12'h020, 32'h80000000, 32'h0,       1'b0, 32'h0,        1'b1, 5, 0);
        run_vec("reg_zero",  1'b0, 1'b0, 1'b1, 12'h060, 32'h12345678, 32'h100,     1'b1, 32'h12345678, 1'b1, 1, 0);
        run_vec("reg_ror32", 1'b0, 1'b0, 1'b1, 12'h060, 32'h80000001, 32'd32,      1'b0, 32'h80000001, 1'b1, 1, 0);
        run_vec("reg_ror36", 1'b0, 1'b0, 1'b1, 12'h060, 32'h0000000F, 32'd36,      1'b0, 32'hF0000000, 1'b1, 2, 0);
        run_vec("imm_lsr4",  1'b0, 1'b0, 1'b0, 12'h220, 32'h000000F8, 32'h0,       1'b0, 32'h0000000F, 1'b1, 2, 0);
        run_vec("imm_asr12", 1'b0, 1'b0, 1'b0, 12'h640, 32'h80001800, 32'h0,       1'b0, 32'hFFF80001, 1'b1, 3, 0);
        run_vec("reg_lsl33", 1'b0, 1'b0, 1'b1, 12'h000, 32'hFFFFFFFF, 32'd33,      1'b1, 32'h0,        1'b0, 6, 0);
        run_vec("reg_lsl32", 1'b0, 1'b0, 1'b1, 12'h000, 32'h00000001, 32'd32,      1'b0, 32'h0,        1'b1, 5, 0);

        // Reset in the middle of a long shift.
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b1, 12'h020, 32'hFFFFFFFF, 32'd40, 1'b1);
        @(posedge clk);
        #1;
        scramble();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_shift", {31'd0, in_ready, out_valid, carry_out, val2}, {31'd0, 1'b1, 1'b0, 1'b0, 32'h0});
        ov_seen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ov_seen++;
        end
        check("rst_no_valid", 64'(ov_seen), 64'(0));
        run_vec("after_rst", 1'b1, 1'b0, 1'b0, 12'h4FF, 32'h0,        32'h0,       1'b0, 32'hFF000000, 1'b1, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/val2_iter_shifter.md
VAL2_ITER_SHIFTER -- requirements
Module: val2_iter_shifter

Interface
REQ-001 Parameter DATA_W, default 32: operand/result width; power of two, >= 16.
REQ-002 Parameter STEP, default 8: max bits shifted per cycle; power of two, 1..DATA_W.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 shifter_operand  input  12  ARM operand2 field.
REQ-008 I  input  1  32-bit immediate form.
REQ-009 mem_en  input  1  memory offset form; overrides I.
REQ-010 reg_shift  input  1  shift amount from val_Rs[7:0], not shifter_operand[11:7].
REQ-011 val_Rm  input  DATA_W  register operand.
REQ-012 val_Rs  input  DATA_W  shift-amount register.
REQ-013 carry_in  input  1  current C flag.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer takes result.
REQ-016 val2  output  DATA_W  shifter result.
REQ-017 carry_out  output  1  shifter carry-out.

Function
REQ-018 States IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-019 Accept on in_valid && in_ready: latch work reg, mode, remaining amount (amt), carry=carry_in; go SHIFT if amt>0, else DONE.
REQ-020 mem_en: work = sign-extend(shifter_operand) to DATA_W, amt=0.
REQ-021 I && !mem_en: work = zero-extend(operand[7:0]), mode ROR, amt = 2*operand[11:8].
REQ-022 Otherwise: work=val_Rm; mode=operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); raw = reg_shift ? val_Rs[7:0] : operand[11:7].
REQ-023 Immediate amount 0: LSL -> amt 0; LSR/ASR -> amt DATA_W; ROR -> RRX single step (result {carry_in, Rm[DATA_W-1:1]}, carry Rm[0]).
REQ-024 Register amount 0: amt 0 any mode, carry_out=carry_in.
REQ-025 LSL/LSR amount clamped to DATA_W+1, ASR to DATA_W; >DATA_W yields result 0, carry 0 (ASR: all sign, carry sign).
REQ-026 ROR amount: amt = raw mod DATA_W; if raw!=0 and mod==0, result=work, carry=work[DATA_W-1], amt 0.
REQ-027 Each SHIFT cycle shifts by k=min(amt,STEP), amt-=k, carry = last bit shifted out; DONE when amt reaches 0.
REQ-028 Latency: out_valid rises ceil(amt/STEP)+1 edges after acceptance (1 edge when amt=0).
REQ-029 DONE holds val2/carry_out stable until out_ready; DONE->IDLE on out_ready; no new accept in same cycle.
REQ-030 in_valid ignored outside IDLE; inputs need not be held after acceptance.
REQ-031 Immediate-rotate carry_out = carry_in when operand[11:8]==0, else result[DATA_W-1].

Reset
REQ-032 rst low asynchronously forces IDLE, val2=0, carry_out=0, amt=0, out_valid=0, in_ready=1 on release.
REQ-033 Reset mid-SHIFT or mid-DONE discards the operation; no partial result is ever presented.

Structure
REQ-034 Shift-type codes (LSL/LSR/ASR/ROR), state encoding, RRX flag encoding belong in the shared package.
REQ-035 One sub-module natural: val2_step_shifter, combinational, shifts by 0..STEP with carry, instantiated once.

Verification
REQ-036 Imm: I=1, operand=0x4FF, carry_in=0 -> val2=0xFF000000, carry 1, out_valid after 2 edges (STEP=8).
REQ-037 Reg LSL: Rm=0x1, operand=LSL#31 imm form -> val2=0x80000000, carry 0, out_valid after 5 edges.
REQ-038 RRX: operand ROR#0, Rm=0x3, carry_in=1 -> val2=0x80000001, carry 1.
REQ-039 Register shift: reg_shift=1, Rs=40, LSR, Rm=0xFFFFFFFF -> val2=0, carry 0; Rs=32 ASR Rm=0x80000000 -> 0xFFFFFFFF, carry 1.
REQ-040 mem_en: operand=0x800 -> val2=0xFFFFF800 after 1 edge; hold out_ready=0 3 cycles -> val2 stable, in_ready=0.
REQ-041 Assert rst during SHIFT -> immediate IDLE, out_valid never rises for that request; next request completes correctly.
